// File: rtl/mem_wb_if.sv
// mem_wb_if: bundles the MEM->WB stage inputs and the register-file write port.
//   Pipeline controls : Stall_i, Flush_i, Valid_i
//   Write-back control: Reg_Write_i, Mem_To_Reg_i, Write_Register_i
//   Load formatting   : Load_Size_i, Load_Unsigned_i, Byte_Offset_i
//   Data              : ALU_Result_i, Mem_Data_i
//   Outputs           : Reg_Write_o, Write_Register_o, Write_Data_o, Valid_o, Retired_o
// The slave modport is the stage; the master modport is whoever drives it.
interface mem_wb_if #(
  parameter int unsigned N_bits = 32
);
  logic              Stall_i;
  logic              Flush_i;
  logic              Valid_i;
  logic              Reg_Write_i;
  logic              Mem_To_Reg_i;
  logic [1:0]        Load_Size_i;
  logic              Load_Unsigned_i;
  logic [1:0]        Byte_Offset_i;
  logic [N_bits-1:0] ALU_Result_i;
  logic [N_bits-1:0] Mem_Data_i;
  logic [4:0]        Write_Register_i;
  logic              Reg_Write_o;
  logic [4:0]        Write_Register_o;
  logic [N_bits-1:0] Write_Data_o;
  logic              Valid_o;
  logic [31:0]       Retired_o;

  modport master (
    output Stall_i, Flush_i, Valid_i, Reg_Write_i, Mem_To_Reg_i, Load_Size_i,
           Load_Unsigned_i, Byte_Offset_i, ALU_Result_i, Mem_Data_i, Write_Register_i,
    input  Reg_Write_o, Write_Register_o, Write_Data_o, Valid_o, Retired_o
  );

  modport slave (
    input  Stall_i, Flush_i, Valid_i, Reg_Write_i, Mem_To_Reg_i, Load_Size_i,
           Load_Unsigned_i, Byte_Offset_i, ALU_Result_i, Mem_Data_i, Write_Register_i,
    output Reg_Write_o, Write_Register_o, Write_Data_o, Valid_o, Retired_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register for the MIPS datapath.
// Selects ALU result or load data (big-endian byte/half extraction with sign or
// zero extension), registers it with the destination and write enable, and
// drives the register file write port. Supports stall (hold) and flush (bubble,
// priority over stall); writes to $zero are suppressed. Retired_o counts
// instructions leaving WB.
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear of all state
//   bus   : mem_wb_if slave (stage inputs and register-file write port)
module mem_wb_stage #(
  parameter int unsigned N_bits = 32  // load alignment assumes 32
) (
  input logic       clk,
  input logic       reset,
  mem_wb_if.slave   bus
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [N_bits-1:0] w_load;
  logic [N_bits-1:0] w_next_data;
  logic              w_retire;

  logic              r_valid;
  logic              r_reg_write;
  logic [4:0]        r_write_register;
  logic [N_bits-1:0] r_write_data;
  logic [31:0]       r_retired;

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    unique case (bus.Byte_Offset_i)
      2'd0: w_byte = bus.Mem_Data_i[31:24];
      2'd1: w_byte = bus.Mem_Data_i[23:16];
      2'd2: w_byte = bus.Mem_Data_i[15:8];
      2'd3: w_byte = bus.Mem_Data_i[7:0];
      default: w_byte = 8'h00;
    endcase
    // Misaligned halves fall back to the aligned half; no trap is raised here.
    w_half = bus.Byte_Offset_i[1] ? bus.Mem_Data_i[15:0] : bus.Mem_Data_i[31:16];

    unique case (bus.Load_Size_i)
      2'b01: w_load = bus.Load_Unsigned_i ? {{(N_bits-16){1'b0}}, w_half}
                                          : {{(N_bits-16){w_half[15]}}, w_half};
      2'b10: w_load = bus.Load_Unsigned_i ? {{(N_bits-8){1'b0}}, w_byte}
                                          : {{(N_bits-8){w_byte[7]}}, w_byte};
      default: w_load = bus.Mem_Data_i;
    endcase

    w_next_data = bus.Mem_To_Reg_i ? w_load : bus.ALU_Result_i;
  end

  // A flushed instruction already wrote back, so it counts as retired too.
  assign w_retire = r_valid & (bus.Flush_i | ~bus.Stall_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid          <= 1'b0;
      r_reg_write      <= 1'b0;
      r_write_register <= 5'd0;
      r_write_data     <= '0;
      r_retired        <= 32'd0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
      end
      if (bus.Flush_i) begin
        r_valid <= 1'b0;
      end else if (!bus.Stall_i) begin
        r_valid          <= bus.Valid_i;
        r_reg_write      <= bus.Reg_Write_i;
        r_write_register <= bus.Write_Register_i;
        r_write_data     <= w_next_data;
      end
    end
  end

  assign bus.Reg_Write_o      = r_valid & r_reg_write & (r_write_register != 5'd0);
  assign bus.Write_Register_o = r_write_register;
  assign bus.Write_Data_o     = r_write_data;
  assign bus.Valid_o          = r_valid;
  assign bus.Retired_o        = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage with a behavioural model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  mem_wb_if #(.N_bits(32)) bus ();

  mem_wb_stage #(.N_bits(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the stage should be holding.
  logic        m_valid = 1'b0;
  logic        m_rw    = 1'b0;
  logic [4:0]  m_wr    = 5'd0;
  logic [31:0] m_data  = 32'd0;
  logic [31:0] m_ret   = 32'd0;

  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    int unsigned shift;
    int unsigned width;
    logic [31:0] mask;
    logic [31:0] val;
    if (sz == 2'b10) begin
      width = 8;
      shift = 8 * (3 - int'(off));
    end else if (sz == 2'b01) begin
      width = 16;
      shift = (off >= 2'd2) ? 0 : 16;
    end else begin
      return mem;
    end
    mask = (32'd1 << width) - 32'd1;
    val  = (mem >> shift) & mask;
    if (!uns && val[width-1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic m_rw_out();
    return m_valid && m_rw && (m_wr != 5'd0);
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input logic st, input logic fl, input logic v, input logic rw,
                       input logic m2r, input logic [1:0] sz, input logic uns,
                       input logic [1:0] off, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] wr);
    logic retire;
    bus.Stall_i = st;          bus.Flush_i = fl;        bus.Valid_i = v;
    bus.Reg_Write_i = rw;      bus.Mem_To_Reg_i = m2r;  bus.Load_Size_i = sz;
    bus.Load_Unsigned_i = uns; bus.Byte_Offset_i = off; bus.ALU_Result_i = alu;
    bus.Mem_Data_i = mem;      bus.Write_Register_i = wr;
    retire = m_valid && (fl || !st);
    if (fl) begin
      m_valid = 1'b0;
    end else if (!st) begin
      m_valid = v;
      m_rw    = rw;
      m_wr    = wr;
      m_data  = m2r ? ref_load(mem, sz, uns, off) : alu;
    end
    if (retire) m_ret = m_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, $urandom, $urandom, 5'd0);
  endtask

  task automatic test_reset();
    bus.Stall_i = 0; bus.Flush_i = 0; bus.Valid_i = 1; bus.Reg_Write_i = 1;
    bus.Mem_To_Reg_i = 0; bus.Load_Size_i = 0; bus.Load_Unsigned_i = 0;
    bus.Byte_Offset_i = 0; bus.ALU_Result_i = 32'hFFFF_FFFF; bus.Mem_Data_i = 0;
    bus.Write_Register_i = 5'd9;
    #12;
    n_cmp += 5;
    if (bus.Reg_Write_o !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %0b want 0", bus.Reg_Write_o); end
    if (bus.Write_Register_o !== 5'd0) begin n_fail++; $display("FAIL reset_wr got %0d want 0", bus.Write_Register_o); end
    if (bus.Write_Data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.Write_Data_o); end
    if (bus.Valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.Valid_o); end
    if (bus.Retired_o !== 32'd0) begin n_fail++; $display("FAIL reset_ret got %0d want 0", bus.Retired_o); end
    #1 reset = 1'b1;
  endtask

  task automatic test_alu();
    logic [31:0] base;
    idle();
    idle();
    base = m_ret;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h1234_5678, $urandom, 5'd5);
    n_cmp += 4;
    if (bus.Reg_Write_o !== 1'b1) begin n_fail++; $display("FAIL alu_rw got %0b want 1", bus.Reg_Write_o); end
    if (bus.Write_Register_o !== 5'd5) begin n_fail++; $display("FAIL alu_wr got %0d want 5", bus.Write_Register_o); end
    if (bus.Write_Data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data got %h want 12345678", bus.Write_Data_o); end
    if (bus.Retired_o !== base) begin n_fail++; $display("FAIL alu_ret0 got %0d want %0d", bus.Retired_o, base); end
    idle();
    n_cmp++;
    if (bus.Retired_o !== base + 32'd1) begin n_fail++; $display("FAIL alu_ret1 got %0d want %0d", bus.Retired_o, base + 32'd1); end
  endtask

  typedef struct packed {
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  task automatic test_loads();
    load_vec_t tbl [8];
    tbl[0] = '{sz: 2'b10, uns: 1'b0, off: 2'd1, exp: 32'hFFFF_FFF1};
    tbl[1] = '{sz: 2'b10, uns: 1'b1, off: 2'd1, exp: 32'h0000_00F1};
    tbl[2] = '{sz: 2'b10, uns: 1'b0, off: 2'd2, exp: 32'h0000_007F};
    tbl[3] = '{sz: 2'b01, uns: 1'b0, off: 2'd0, exp: 32'hFFFF_80F1};
    tbl[4] = '{sz: 2'b01, uns: 1'b1, off: 2'd2, exp: 32'h0000_7F02};
    tbl[5] = '{sz: 2'b00, uns: 1'b0, off: 2'd0, exp: 32'h80F1_7F02};
    tbl[6] = '{sz: 2'b01, uns: 1'b0, off: 2'd3, exp: 32'h0000_7F02};
    tbl[7] = '{sz: 2'b11, uns: 1'b1, off: 2'd1, exp: 32'h80F1_7F02};
    foreach (tbl[i]) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, tbl[i].sz, tbl[i].uns, tbl[i].off, $urandom,
            32'h80F1_7F02, 5'd3);
      n_cmp++;
      if (bus.Write_Data_o !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL load%0d got %h want %h", i, bus.Write_Data_o, tbl[i].exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hDEAD_BEEF, $urandom, 5'd0);
    n_cmp += 3;
    if (bus.Reg_Write_o !== 1'b0) begin n_fail++; $display("FAIL zero_rw got %0b want 0", bus.Reg_Write_o); end
    if (bus.Write_Data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_data got %h want deadbeef", bus.Write_Data_o); end
    if (bus.Valid_o !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %0b want 1", bus.Valid_o); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] base;
    logic [31:0] alu;
    alu = $urandom;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, alu, $urandom, 5'd7);
    base = m_ret;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            2'($urandom), $urandom, $urandom, 5'($urandom));
      n_cmp += 5;
      if (bus.Reg_Write_o !== 1'b1) begin n_fail++; $display("FAIL stall%0d_rw got %0b want 1", k, bus.Reg_Write_o); end
      if (bus.Write_Register_o !== 5'd7) begin n_fail++; $display("FAIL stall%0d_wr got %0d want 7", k, bus.Write_Register_o); end
      if (bus.Write_Data_o !== alu) begin n_fail++; $display("FAIL stall%0d_data got %h want %h", k, bus.Write_Data_o, alu); end
      if (bus.Valid_o !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid got %0b want 1", k, bus.Valid_o); end
      if (bus.Retired_o !== base) begin n_fail++; $display("FAIL stall%0d_ret got %0d want %0d", k, bus.Retired_o, base); end
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, $urandom, $urandom, 5'd9);
    n_cmp += 5;
    if (bus.Valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", bus.Valid_o); end
    if (bus.Reg_Write_o !== 1'b0) begin n_fail++; $display("FAIL flush_rw got %0b want 0", bus.Reg_Write_o); end
    if (bus.Write_Register_o !== 5'd7) begin n_fail++; $display("FAIL flush_wr got %0d want 7", bus.Write_Register_o); end
    if (bus.Write_Data_o !== alu) begin n_fail++; $display("FAIL flush_data got %h want %h", bus.Write_Data_o, alu); end
    if (bus.Retired_o !== base + 32'd1) begin n_fail++; $display("FAIL flush_ret got %0d want %0d", bus.Retired_o, base + 32'd1); end
    idle();
    n_cmp++;
    if (bus.Retired_o !== base + 32'd1) begin n_fail++; $display("FAIL flush_once got %0d want %0d", bus.Retired_o, base + 32'd1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      n_cmp += 5;
      if (bus.Reg_Write_o !== m_rw_out()) begin n_fail++; $display("FAIL rnd%0d_rw got %0b want %0b", k, bus.Reg_Write_o, m_rw_out()); end
      if (bus.Write_Register_o !== m_wr) begin n_fail++; $display("FAIL rnd%0d_wr got %0d want %0d", k, bus.Write_Register_o, m_wr); end
      if (bus.Write_Data_o !== m_data) begin n_fail++; $display("FAIL rnd%0d_data got %h want %h", k, bus.Write_Data_o, m_data); end
      if (bus.Valid_o !== m_valid) begin n_fail++; $display("FAIL rnd%0d_valid got %0b want %0b", k, bus.Valid_o, m_valid); end
      if (bus.Retired_o !== m_ret) begin n_fail++; $display("FAIL rnd%0d_ret got %0d want %0d", k, bus.Retired_o, m_ret); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hA5A5_0001, $urandom, 5'd12);
    bus.Stall_i = 1'b1;
    bus.Flush_i = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.Reg_Write_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rw got %0b want 0", bus.Reg_Write_o); end
    if (bus.Write_Register_o !== 5'd0) begin n_fail++; $display("FAIL midrst_wr got %0d want 0", bus.Write_Register_o); end
    if (bus.Write_Data_o !== 32'd0) begin n_fail++; $display("FAIL midrst_data got %h want 0", bus.Write_Data_o); end
    if (bus.Valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", bus.Valid_o); end
    if (bus.Retired_o !== 32'd0) begin n_fail++; $display("FAIL midrst_ret got %0d want 0", bus.Retired_o); end
    @(negedge clk);
    reset = 1'b1;
    m_valid = 1'b0; m_rw = 1'b0; m_wr = 5'd0; m_data = 32'd0; m_ret = 32'd0;
    #1;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0BAD_F00D, $urandom, 5'd20);
    n_cmp += 3;
    if (bus.Write_Data_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL postrst_data got %h want 0badf00d", bus.Write_Data_o); end
    if (bus.Reg_Write_o !== 1'b1) begin n_fail++; $display("FAIL postrst_rw got %0b want 1", bus.Reg_Write_o); end
    if (bus.Retired_o !== 32'd0) begin n_fail++; $display("FAIL postrst_ret got %0d want 0", bus.Retired_o); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, $urandom, $urandom, 5'd4);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    m_ret = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, $urandom, $urandom, 5'd4);
    n_cmp++;
    if (bus.Retired_o !== 32'd0) begin n_fail++; $display("FAIL wrap got %h want 0", bus.Retired_o); end
    idle();
    n_cmp++;
    if (bus.Retired_o !== 32'd1) begin n_fail++; $display("FAIL wrap_next got %h want 1", bus.Retired_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_zero_reg();
    test_stall_flush();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline stage for the MIPS datapath: registers the memory-stage result, selects ALU result or load data, performs byte/halfword load alignment and sign/zero extension, and drives the write port of the register file. Holds, flushes and suppresses writes to $zero. Keeps a retired-instruction counter for the bench and for debug.

## Interface
- N_bits, 32, data width; load alignment requires N_bits = 32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- Stall_i  in  1  hold current contents (no capture).
- Flush_i  in  1  insert bubble; has priority over Stall_i.
- Valid_i  in  1  MEM stage holds a real instruction.
- Reg_Write_i  in  1  instruction writes a register.
- Mem_To_Reg_i  in  1  1 = load data, 0 = ALU result.
- Load_Size_i  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- Load_Unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
- Byte_Offset_i  in  2  address bits [1:0] of the load.
- ALU_Result_i  in  N_bits  ALU / link result.
- Mem_Data_i  in  N_bits  raw aligned word from data memory.
- Write_Register_i  in  5  destination register number.
- Reg_Write_o  out  1  register file write enable.
- Write_Register_o  out  5  register file write address.
- Write_Data_o  out  N_bits  register file write data.
- Valid_o  out  1  stage holds a real instruction.
- Retired_o  out  32  count of retired instructions.

## Operation
- Load extraction, combinational on inputs, big-endian lane order: byte at offset 0 = Mem_Data_i[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; half at offset 0 = [31:16], 2 = [15:0]; half with offset bit0 = 1 uses offset & 2'b10 (no trap).
- Extension: Load_Unsigned_i = 1 → zero-fill upper bits; 0 → replicate selected MSB.
- Word loads ignore Byte_Offset_i and Load_Unsigned_i.
- Next data = Mem_To_Reg_i ? extended load : ALU_Result_i.
- Per rising edge, in priority: reset low → clear; Flush_i → valid_q = 0, other fields unchanged; Stall_i → hold all; else capture Valid_i, Reg_Write_i, Write_Register_i, next data.
- Reg_Write_o = valid_q & reg_write_q & (Write_Register_o != 0); writes to $zero never leave the block.
- Write_Register_o and Write_Data_o come straight from registers, driven even when Reg_Write_o = 0.
- Retired_o increments by 1 on each edge where valid_q = 1 and the stage is not stalled (the instruction leaves WB). A flush with valid_q = 1 also counts, because the held instruction has already written back. Wraps 0xFFFFFFFF → 0.

## Timing
- Latency: one cycle from inputs to outputs; all outputs registered, no combinational input→output path.
- Reset (async assert, sync-safe release): Reg_Write_o = 0, Write_Register_o = 0, Write_Data_o = 0, Valid_o = 0, Retired_o = 0.
- Reset asserted mid-stall or mid-flush: immediate clear; the first edge after release captures normally.
- Stall held N cycles: outputs constant N cycles, Reg_Write_o re-asserts each cycle (the register file rewrites the same value, which is harmless).
- Flush and Stall together: flush wins, bubble inserted.
- Register file writes on the edge after Reg_Write_o is seen; data is readable by ID the following cycle (no internal bypass here).

## Test plan
- Reset: drive reset = 0 mid-run with Valid_o = 1 → all outputs 0 immediately; Retired_o = 0.
- ALU path: Valid = 1, Reg_Write = 1, Mem_To_Reg = 0, ALU = 0x12345678, Wr = 5 → next cycle Reg_Write_o = 1, Write_Register_o = 5, Write_Data_o = 0x12345678, Retired_o increments by 1 on the following edge.
- Loads from Mem_Data = 0x80F17F02:
  - lb offset 1 → 0xFFFFFFF1
  - lbu offset 1 → 0x000000F1
  - lb offset 2 → 0x0000007F
  - lh offset 0 → 0xFFFF80F1
  - lhu offset 2 → 0x00007F02
  - lw → 0x80F17F02
- $zero: Reg_Write = 1, Wr = 0, ALU = 0xDEADBEEF → Reg_Write_o = 0, Write_Data_o = 0xDEADBEEF, Valid_o = 1.
- Stall/flush: capture Wr = 7; Stall 3 cycles while inputs change → outputs unchanged; then Flush with Stall = 1 → Valid_o = 0, Reg_Write_o = 0, Retired_o + 1 exactly once.
- Counter wrap: preload via 2^32 − 1 retirements (or force) → next retirement yields Retired_o = 0.
